stopwatch_timer: RTL and testbench

Parametrised successor of the lab stopwatch. It is a BCD minute/second/tenth counter with start/stop/resume, count-up or count-down (timer) modes, preset load, and saturation at both limits instead of wrap-to-idle. It sits between the debounce/one-pulse front end and the 7-segment scan logic, and delivers a flat BCD digit bus plus status.

---
 rtl/stopwatch_pkg.sv | 40 ++++
 rtl/bcd_digit_counter.sv | 51 +++++
 rtl/stopwatch_timer.sv | 214 +++++++++++++++++++++
 tb/tb_stopwatch_timer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared types and constants for the stopwatch_timer block:
//            FSM state encoding, per-digit BCD limits, digit positions in
//            the flat BCD bus, and small helpers for limit lookup/clamping.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_t;

  localparam logic [3:0] DIG_MAX_DEC      = 4'd9;
  localparam logic [3:0] DIG_MAX_SEC_TENS = 4'd5;

  // Digit positions in the flat bus (each digit is 4 bits wide)
  localparam int DIG_TENTHS    = 0;
  localparam int DIG_SEC_UNITS = 1;
  localparam int DIG_SEC_TENS  = 2;
  localparam int DIG_MIN_BASE  = 3;

  // Only the seconds-tens digit stops at 5; every other digit is decimal.
  function automatic logic [3:0] digit_limit(input int idx);
    return (idx == DIG_SEC_TENS) ? DIG_MAX_SEC_TENS : DIG_MAX_DEC;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] val,
                                             input logic [3:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_counter
// Purpose  : One BCD digit of the stopwatch count. Wraps 0..LIMIT in either
//            direction and reports carry (up) / borrow (down) to the next
//            digit. A synchronous load overrides counting.
// Ports    : clk, rst_n        - clock, async active-low reset
//            i_load/i_load_val - synchronous load of a digit value
//            i_en              - step this digit on this edge
//            i_up              - 1 = increment, 0 = decrement
//            o_value           - current digit value
//            o_carry           - step request for the next digit
// Config   : LIMIT - highest legal digit value
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_counter #(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  input  logic       i_up,
  output logic [3:0] o_value,
  output logic       o_carry
);

  logic [3:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 4'd0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_en) begin
      if (i_up) begin
        r_value <= (r_value == LIMIT) ? 4'd0 : r_value + 4'd1;
      end else begin
        r_value <= (r_value == 4'd0) ? LIMIT : r_value - 4'd1;
      end
    end
  end

  // Carry/borrow is combinational so the whole chain steps on the same edge.
  assign o_carry = i_en && !i_load &&
                   (i_up ? (r_value == LIMIT) : (r_value == 4'd0));
  assign o_value = r_value;

endmodule : bcd_digit_counter
`default_nettype wire

// File: rtl/stopwatch_timer.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_timer
// Purpose  : BCD minute/second/tenth stopwatch and countdown timer with
//            start/stop/resume, preset load, and saturation at both limits.
// Ports    : clk, rst_n    - clock, async active-low reset
//            start_stop    - pulse, toggles run/pause (start from IDLE)
//            clear         - pulse, back to IDLE with count reloaded
//            mode          - 0 = up, 1 = down (taken in IDLE only)
//            load_en       - pulse, latch clamped load_value (IDLE only)
//            load_value    - preset digits, tenths in [3:0], LSD first
//            lap           - pulse, toggles display freeze
//            disp_bcd      - displayed digits, same layout as load_value
//            running       - high while in RUN
//            done          - one-cycle pulse when a limit is reached
//            tick          - one-cycle pulse per counted 0.1 s
// Config   : STOPWATCH_LAP_EN - when defined, builds the lap snapshot
//            register; otherwise lap is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV       = 10000000,
  parameter int NUM_MIN_DIGITS = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_stop,
  input  logic                            clear,
  input  logic                            mode,
  input  logic                            load_en,
  input  logic [4*(3+NUM_MIN_DIGITS)-1:0] load_value,
  input  logic                            lap,
  output logic [4*(3+NUM_MIN_DIGITS)-1:0] disp_bcd,
  output logic                            running,
  output logic                            done,
  output logic                            tick
);

  localparam int D  = 3 + NUM_MIN_DIGITS;
  localparam int W  = 4 * D;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t      r_state;
  logic [PW-1:0]  r_presc;
  logic [W-1:0]   r_preset;
  logic           r_mode;
  logic           r_running;
  logic           r_done;
  logic           r_tick;

  logic [W-1:0]   w_count;
  logic [W-1:0]   w_clamped;
  logic [D-1:0]   w_at_max;
  logic [D-1:0]   w_dig_en;
  logic [D-1:0]   w_dig_co;
  logic           w_at_limit;
  logic           w_tick_evt;
  logic           w_cnt_en;
  logic           w_cnt_load;
  logic [W-1:0]   w_cnt_load_val;
  logic           w_unused_top_carry;

  // A tick "at the limit" is the event that ends the run; it never steps
  // the count, which is what makes the count saturate.
  assign w_at_limit     = r_mode ? (w_count == '0) : (&w_at_max);
  assign w_tick_evt     = (r_state == ST_RUN) && (r_presc == PRESC_LAST) && !clear;
  assign w_cnt_en       = w_tick_evt && !w_at_limit;
  // IDLE continuously tracks the reload value so mode/preset changes show
  // immediately; clear reloads on its own edge.
  assign w_cnt_load     = clear || (r_state == ST_IDLE);
  assign w_cnt_load_val = mode ? r_preset : '0;

  for (genvar g = 0; g < D; g++) begin : g_digit
    localparam logic [3:0] LIM = digit_limit(g);

    if (g == 0) begin : g_lsd
      assign w_dig_en[g] = w_cnt_en;
    end else begin : g_chain
      assign w_dig_en[g] = w_dig_co[g-1];
    end

    bcd_digit_counter #(
      .LIMIT (LIM)
    ) u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val[4*g +: 4]),
      .i_en       (w_dig_en[g]),
      .i_up       (!r_mode),
      .o_value    (w_count[4*g +: 4]),
      .o_carry    (w_dig_co[g])
    );

    assign w_clamped[4*g +: 4] = clamp_digit(load_value[4*g +: 4], LIM);
    assign w_at_max[g]         = (w_count[4*g +: 4] == LIM);
  end

  assign w_unused_top_carry = w_dig_co[D-1];

`ifdef STOPWATCH_LAP_EN
  logic           r_lap_frz;
  logic [W-1:0]   r_lap_val;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_preset  <= '0;
      r_mode    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_tick    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_lap_frz <= 1'b0;
      r_lap_val <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_tick <= 1'b0;

      if (clear) begin
        r_state   <= ST_IDLE;
        r_presc   <= '0;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_mode  <= mode;
            r_presc <= '0;
            if (load_en) begin
              r_preset <= w_clamped;
            end else if (start_stop) begin
              if (mode && (r_preset == '0)) begin
                // Countdown from zero has nothing to count: finish at once.
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state   <= ST_RUN;
                r_running <= 1'b1;
              end
            end
          end

          ST_RUN: begin
            if (r_presc == PRESC_LAST) begin
              r_presc <= '0;
            end else begin
              r_presc <= r_presc + 1'b1;
            end

            if (w_tick_evt && w_at_limit) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_running <= 1'b0;
            end else begin
              r_tick <= w_tick_evt;
              if (start_stop) begin
                r_state   <= ST_PAUSE;
                r_running <= 1'b0;
              end
            end
          end

          ST_PAUSE: begin
            // Prescaler holds so the partial tick resumes where it stopped.
            if (start_stop) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end

          ST_DONE: begin
            // Held until clear.
          end

          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end

`ifdef STOPWATCH_LAP_EN
      if (clear) begin
        r_lap_frz <= 1'b0;
      end else if (lap && ((r_state == ST_RUN) || (r_state == ST_PAUSE))) begin
        r_lap_frz <= !r_lap_frz;
        if (!r_lap_frz) begin
          r_lap_val <= w_count;
        end
      end
`endif
    end
  end

`ifdef STOPWATCH_LAP_EN
  assign disp_bcd = r_lap_frz ? r_lap_val : w_count;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign disp_bcd     = w_count;
`endif

  assign running = r_running;
  assign done    = r_done;
  assign tick    = r_tick;

endmodule : stopwatch_timer
`default_nettype wire

// File: tb/tb_stopwatch_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_timer
// Purpose  : Directed self-checking bench for stopwatch_timer with
//            TICK_DIV = 4 and one minute digit (16-bit BCD bus).
// Config   : exercises the lap freeze when STOPWATCH_LAP_EN is defined,
//            otherwise checks that lap has no effect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_timer;

  logic        clk;
  logic        rst_n;
  logic        start_stop;
  logic        clear;
  logic        mode;
  logic        load_en;
  logic [15:0] load_value;
  logic        lap;
  logic [15:0] disp_bcd;
  logic        running;
  logic        done;
  logic        tick;

  int total;
  int bad;

  stopwatch_timer #(
    .TICK_DIV       (4),
    .NUM_MIN_DIGITS (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .mode       (mode),
    .load_en    (load_en),
    .load_value (load_value),
    .lap        (lap),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .done       (done),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs change and outputs are sampled 1 ns after.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic pulse_load(input logic [15:0] val);
    load_value = val;
    load_en    = 1'b1;
    step(1);
    load_en    = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    total++;
    if (disp_bcd !== 16'h0000 || running !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: disp=%h run=%b done=%b tick=%b required disp=0000 run=0 done=0 tick=0",
               disp_bcd, running, done, tick);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_up_count();
    logic seen_done;
    pulse_clear();
    pulse_ss();
    total++;
    if (running !== 1'b1) begin
      bad++;
      $display("FAIL up_running: running=%b required 1", running);
    end
    step(40);
    total++;
    if (disp_bcd !== 16'h0010) begin
      bad++;
      $display("FAIL up_1s: disp=%h required 0010", disp_bcd);
    end
    step(4 * 589);
    total++;
    if (disp_bcd !== 16'h0599) begin
      bad++;
      $display("FAIL up_59_9: disp=%h required 0599", disp_bcd);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (done === 1'b1) seen_done = 1'b1;
    end
    total++;
    if (disp_bcd !== 16'h1000 || seen_done !== 1'b0) begin
      bad++;
      $display("FAIL up_minute_carry: disp=%h done_seen=%b required 1000 / 0", disp_bcd, seen_done);
    end
    pulse_clear();
    total++;
    if (disp_bcd !== 16'h0000 || running !== 1'b0) begin
      bad++;
      $display("FAIL up_clear: disp=%h run=%b required 0000 / 0", disp_bcd, running);
    end
  endtask

  task automatic test_pause_resume();
    logic seen_tick;
    pulse_clear();
    pulse_ss();
    step(5);
    pulse_ss();
    total++;
    if (disp_bcd !== 16'h0001 || running !== 1'b0) begin
      bad++;
      $display("FAIL pause_enter: disp=%h run=%b required 0001 / 0", disp_bcd, running);
    end
    seen_tick = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (tick === 1'b1) seen_tick = 1'b1;
    end
    total++;
    if (disp_bcd !== 16'h0001 || seen_tick !== 1'b0) begin
      bad++;
      $display("FAIL pause_hold: disp=%h tick_seen=%b required 0001 / 0", disp_bcd, seen_tick);
    end
    pulse_ss();
    step(1);
    total++;
    if (tick !== 1'b0 || running !== 1'b1) begin
      bad++;
      $display("FAIL resume_early: tick=%b run=%b required 0 / 1", tick, running);
    end
    step(1);
    total++;
    if (tick !== 1'b1 || disp_bcd !== 16'h0002) begin
      bad++;
      $display("FAIL resume_tick: tick=%b disp=%h required 1 / 0002", tick, disp_bcd);
    end
    pulse_clear();
  endtask

  task automatic test_down_timer();
    mode = 1'b1;
    pulse_clear();
    pulse_load(16'h0003);
    step(1);
    total++;
    if (disp_bcd !== 16'h0003) begin
      bad++;
      $display("FAIL down_preset: disp=%h required 0003", disp_bcd);
    end
    pulse_ss();
    step(12);
    total++;
    if (disp_bcd !== 16'h0000 || running !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL down_zero: disp=%h run=%b done=%b required 0000 / 1 / 0", disp_bcd, running, done);
    end
    step(4);
    total++;
    if (done !== 1'b1 || running !== 1'b0 || disp_bcd !== 16'h0000) begin
      bad++;
      $display("FAIL down_done: done=%b run=%b disp=%h required 1 / 0 / 0000", done, running, disp_bcd);
    end
    step(1);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL down_done_pulse: done=%b required 0", done);
    end
    pulse_clear();
    total++;
    if (disp_bcd !== 16'h0003) begin
      bad++;
      $display("FAIL down_reload: disp=%h required 0003", disp_bcd);
    end
    pulse_load(16'h0000);
    step(1);
    pulse_ss();
    total++;
    if (done !== 1'b1 || running !== 1'b0 || tick !== 1'b0) begin
      bad++;
      $display("FAIL down_zero_start: done=%b run=%b tick=%b required 1 / 0 / 0", done, running, tick);
    end
    pulse_clear();
    pulse_load(16'hFA7C);
    step(1);
    total++;
    if (disp_bcd !== 16'h9579) begin
      bad++;
      $display("FAIL load_clamp: disp=%h required 9579", disp_bcd);
    end
    mode = 1'b0;
    pulse_clear();
  endtask

  task automatic test_priority();
    pulse_clear();
    load_value = 16'h0005;
    load_en    = 1'b1;
    start_stop = 1'b1;
    step(1);
    load_en    = 1'b0;
    start_stop = 1'b0;
    total++;
    if (running !== 1'b0) begin
      bad++;
      $display("FAIL load_over_start: run=%b required 0", running);
    end
    pulse_ss();
    step(6);
    clear      = 1'b1;
    start_stop = 1'b1;
    step(1);
    clear      = 1'b0;
    start_stop = 1'b0;
    step(1);
    total++;
    if (running !== 1'b0 || disp_bcd !== 16'h0000) begin
      bad++;
      $display("FAIL clear_over_start: run=%b disp=%h required 0 / 0000", running, disp_bcd);
    end
    pulse_ss();
    step(10);
    total++;
    if (disp_bcd !== 16'h0002 || running !== 1'b1) begin
      bad++;
      $display("FAIL prereset_run: disp=%h run=%b required 0002 / 1", disp_bcd, running);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (disp_bcd !== 16'h0000 || running !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: disp=%h run=%b required 0000 / 0", disp_bcd, running);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_lap();
    pulse_clear();
    pulse_ss();
`ifdef STOPWATCH_LAP_EN
    step(80);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    total++;
    if (disp_bcd !== 16'h0020) begin
      bad++;
      $display("FAIL lap_freeze: disp=%h required 0020", disp_bcd);
    end
    step(39);
    total++;
    if (disp_bcd !== 16'h0020 || tick !== 1'b1) begin
      bad++;
      $display("FAIL lap_hold: disp=%h tick=%b required 0020 / 1", disp_bcd, tick);
    end
    step(80);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    total++;
    if (disp_bcd !== 16'h0050) begin
      bad++;
      $display("FAIL lap_release: disp=%h required 0050", disp_bcd);
    end
`else
    step(8);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    step(3);
    total++;
    if (disp_bcd !== 16'h0003) begin
      bad++;
      $display("FAIL lap_ignored: disp=%h required 0003", disp_bcd);
    end
`endif
    pulse_clear();
  endtask

  task automatic test_saturation();
    pulse_clear();
    pulse_ss();
    step(4 * 5999);
    total++;
    if (disp_bcd !== 16'h9599 || running !== 1'b1) begin
      bad++;
      $display("FAIL sat_max: disp=%h run=%b required 9599 / 1", disp_bcd, running);
    end
    step(3);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL sat_early_done: done=%b required 0", done);
    end
    step(1);
    total++;
    if (done !== 1'b1 || running !== 1'b0 || disp_bcd !== 16'h9599) begin
      bad++;
      $display("FAIL sat_done: done=%b run=%b disp=%h required 1 / 0 / 9599", done, running, disp_bcd);
    end
    step(1);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL sat_done_pulse: done=%b required 0", done);
    end
    pulse_ss();
    step(8);
    total++;
    if (running !== 1'b0 || disp_bcd !== 16'h9599 || done !== 1'b0) begin
      bad++;
      $display("FAIL sat_ignore_start: run=%b disp=%h done=%b required 0 / 9599 / 0", running, disp_bcd, done);
    end
    pulse_clear();
    total++;
    if (disp_bcd !== 16'h0000) begin
      bad++;
      $display("FAIL sat_clear: disp=%h required 0000", disp_bcd);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    mode       = 1'b0;
    load_en    = 1'b0;
    load_value = 16'h0000;
    lap        = 1'b0;

    test_reset();
    test_up_count();
    test_pause_resume();
    test_down_timer();
    test_priority();
    test_lap();
    test_saturation();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stopwatch_timer
`default_nettype wire
